poly_operand_sequencer: RTL and testbench
=========================================

Name: poly_operand_sequencer

Overview:
Initiator for the polynomial unit's serial operand-load protocol. It accepts A, B, C and X in parallel with a single start pulse. It then drives them one at a time onto the unit's data input, pressing and releasing `go` in the same pattern a user would on the board. After the fixed compute latency it captures the unit's 8-bit result and pulses `done`. It sits between a host/test controller and the polynomial unit, replacing the SW/KEY manual load sequence.

Parameters:
WIDTH, 8, operand/result width; must match the polynomial unit's data width
HOLD, 2, cycles seq_go is held high per operand (>=1)
GAP, 2, cycles seq_go is held low after each release (>=1)
LATENCY, 6, cycles waited after the X release phase before sampling dut_result (>=6)

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  asynchronous, active-high reset
start  in  1  request; sampled only in IDLE
a_in  in  WIDTH  coefficient A
b_in  in  WIDTH  coefficient B
c_in  in  WIDTH  coefficient C
x_in  in  WIDTH  variable X
seq_data  out  WIDTH  operand driven to the polynomial unit data input
seq_go  out  1  active-high go to the polynomial unit
dut_result  in  WIDTH  polynomial unit result register
result  out  WIDTH  captured result
busy  out  1  high from the cycle after start is accepted through CAPTURE
done  out  1  one-cycle pulse; result is valid from this cycle
op_idx  out  2  operand currently driven: 0=A, 1=B, 2=C, 3=X

Behaviour:
- Reset: asynchronous, active-high.
  - All outputs go to 0: seq_data, seq_go, result, busy, done, op_idx.
  - State returns to IDLE and the operand latches clear.
  - Reset mid-sequence aborts the sequence immediately; no done pulse.
- All outputs are registered; there is no combinational path from inputs to outputs.
- IDLE:
  - seq_go=0, busy=0.
  - When start=1, latch a_in..x_in, set op_idx=0, and go to SETUP.
  - start while not in IDLE is ignored, with no queuing.
- SETUP (1 cycle): seq_data=operand[op_idx], seq_go=0 → PRESS.
- PRESS (HOLD cycles): seq_go=1, seq_data unchanged → RELEASE.
- RELEASE (GAP cycles): seq_go=0, seq_data unchanged.
  - At the end of RELEASE, if op_idx==3 go to COMPUTE.
  - Otherwise increment op_idx and go to SETUP.
- COMPUTE (LATENCY cycles): seq_go=0, seq_data holds X.
- CAPTURE (1 cycle): at its closing edge, result<=dut_result, done<=1, busy<=0, state→IDLE.
- done is high exactly one cycle and clears on the next edge. A new start may be accepted in the done cycle.
- result holds its value until the next CAPTURE or reset.
- Timing with defaults (start high in cycle 0):
  - Operand k occupies cycles 1+5k..5+5k; PRESS is cycles 2+5k..3+5k.
  - COMPUTE is cycles 21..26, CAPTURE is cycle 27, done is high in cycle 28.
  - General total: done cycle = 4*(1+HOLD+GAP) + LATENCY + 2.
- Data is stable for at least 1 cycle before seq_go rises and for the whole HOLD and GAP window. This satisfies the unit's load-on-go-rise rule.
- Phase timer: a single down-counter sized for max(HOLD, GAP, LATENCY), reloaded on every state entry.
- No arithmetic is performed. Width wrap of the result is the unit's responsibility.

Decomposition:
- Shared package holds:
  - state encoding (IDLE, SETUP, PRESS, RELEASE, COMPUTE, CAPTURE);
  - operand index constants OP_A..OP_X;
  - a default-width constant matching the polynomial unit.
- One natural sub-module, seq_phase_timer: loadable down-counter with a load value input, a load strobe, and a zero flag.

Test Plan:
- Golden path, with the DUT connected to the real polynomial unit: A=1, B=2, C=3, X=2, start in cycle 0 → seq_go high in cycles 2-3, 7-8, 12-13, 17-18; done in cycle 28; result=0x0B.
- Wrap: A=16, B=0, C=5, X=4 → result=0x05, since 256 wraps to 0 in 8 bits.
- start pulsed again in cycle 10 with different operands → ignored; result matches the first operand set; exactly one done.
- Asynchronous reset asserted mid-PRESS of operand C (cycle 12, between edges) → seq_go, busy and op_idx go to 0 without waiting for an edge; no done. A new start after release gives the correct result for the new operands.
- Back-to-back: second start held high in the done cycle → accepted; second result correct; done pulses are exactly 28 cycles apart.
- Parameter sweep HOLD=1, GAP=3, LATENCY=8: seq_go pulses are 1 cycle wide, 5 cycles apart; done cycle = 4*5+8+2 = 30; result is still correct.

Source files
------------

// File: rtl/poly_operand_sequencer_pkg.sv
// Shared definitions for the polynomial-unit operand sequencer: state encoding,
// operand slot indices and the unit's native data width.
package poly_operand_sequencer_pkg;

    localparam int unsigned PolyWidth = 8;

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StPress,
        StRelease,
        StCompute,
        StCapture
    } seq_state_e;

    localparam logic [1:0] OpA = 2'd0;
    localparam logic [1:0] OpB = 2'd1;
    localparam logic [1:0] OpC = 2'd2;
    localparam logic [1:0] OpX = 2'd3;

    function automatic int unsigned phase_max(input int unsigned hold, input int unsigned gap,
                                              input int unsigned latency);
        int unsigned m;
        m = hold;
        if (gap > m) m = gap;
        if (latency > m) m = latency;
        return m;
    endfunction

endpackage

// File: rtl/poly_operand_sequencer_if.sv
// Operand-load bus between the sequencer (master) and the polynomial unit (slave).
interface poly_operand_sequencer_if
    import poly_operand_sequencer_pkg::*;
#(
    parameter int unsigned WIDTH = PolyWidth
);

    logic [WIDTH-1:0] seq_data;
    logic             seq_go;
    logic [WIDTH-1:0] dut_result;

    modport master (
        output seq_data,
        output seq_go,
        input  dut_result
    );

    modport slave (
        input  seq_data,
        input  seq_go,
        output dut_result
    );

endinterface

// File: rtl/poly_operand_sequencer_seq_phase_timer.sv
// Loadable phase down-counter; zero flags the last cycle of the current phase.
module poly_operand_sequencer_seq_phase_timer #(
    parameter int unsigned CntWidth = 3
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                load,
    input  logic [CntWidth-1:0] load_val,
    output logic                zero
);

    logic [CntWidth-1:0] count_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= load_val;
        end else if (count_q != '0) begin
            count_q <= count_q - 1'b1;
        end
    end

    assign zero = (count_q == '0);

endmodule

// File: rtl/poly_operand_sequencer.sv
// Serial operand-load initiator: latches A/B/C/X on start, presents each with a press/release
// of go, then captures the polynomial unit's result after a fixed compute latency.
module poly_operand_sequencer
    import poly_operand_sequencer_pkg::*;
#(
    parameter int unsigned WIDTH   = PolyWidth,
    parameter int unsigned HOLD    = 2,
    parameter int unsigned GAP     = 2,
    parameter int unsigned LATENCY = 6
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [WIDTH-1:0]         a_in,
    input  logic [WIDTH-1:0]         b_in,
    input  logic [WIDTH-1:0]         c_in,
    input  logic [WIDTH-1:0]         x_in,
    poly_operand_sequencer_if.master poly_bus,
    output logic [WIDTH-1:0]         result,
    output logic                     busy,
    output logic                     done,
    output logic [1:0]               op_idx
);

    localparam int unsigned PhaseMax = phase_max(HOLD, GAP, LATENCY);
    localparam int unsigned TmrWidth = $clog2(PhaseMax + 1);

    // A phase of N cycles loads N-1 so that zero marks its final cycle.
    localparam logic [TmrWidth-1:0] HoldLoad = TmrWidth'(HOLD - 1);
    localparam logic [TmrWidth-1:0] GapLoad  = TmrWidth'(GAP - 1);
    localparam logic [TmrWidth-1:0] LatLoad  = TmrWidth'(LATENCY - 1);

    seq_state_e                 state_q;
    logic [3:0][WIDTH-1:0]      ops_q;
    logic [1:0]                 op_idx_q;
    logic [1:0]                 op_next;
    logic [WIDTH-1:0]           seq_data_q;
    logic                       seq_go_q;
    logic [WIDTH-1:0]           result_q;
    logic                       busy_q;
    logic                       done_q;

    logic                       tmr_load;
    logic [TmrWidth-1:0]        tmr_val;
    logic                       tmr_zero;

    assign op_next = op_idx_q + 2'd1;

    // Reload the timer on every state transition with the length of the phase being entered.
    always_comb begin
        tmr_load = 1'b0;
        tmr_val  = '0;
        unique case (state_q)
            StIdle:    tmr_load = start;
            StSetup: begin
                tmr_load = 1'b1;
                tmr_val  = HoldLoad;
            end
            StPress: begin
                tmr_load = tmr_zero;
                tmr_val  = GapLoad;
            end
            StRelease: begin
                tmr_load = tmr_zero;
                tmr_val  = (op_idx_q == OpX) ? LatLoad : '0;
            end
            StCompute: tmr_load = tmr_zero;
            StCapture: tmr_load = 1'b1;
            default:   tmr_load = 1'b0;
        endcase
    end

    poly_operand_sequencer_seq_phase_timer #(
        .CntWidth (TmrWidth)
    ) u_seq_phase_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (tmr_load),
        .load_val (tmr_val),
        .zero     (tmr_zero)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            ops_q      <= '0;
            op_idx_q   <= OpA;
            seq_data_q <= '0;
            seq_go_q   <= 1'b0;
            result_q   <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        ops_q      <= {x_in, c_in, b_in, a_in};
                        op_idx_q   <= OpA;
                        seq_data_q <= a_in;
                        busy_q     <= 1'b1;
                        state_q    <= StSetup;
                    end
                end
                StSetup: begin
                    seq_go_q <= 1'b1;
                    state_q  <= StPress;
                end
                StPress: begin
                    if (tmr_zero) begin
                        seq_go_q <= 1'b0;
                        state_q  <= StRelease;
                    end
                end
                StRelease: begin
                    if (tmr_zero) begin
                        if (op_idx_q == OpX) begin
                            state_q <= StCompute;
                        end else begin
                            op_idx_q   <= op_next;
                            seq_data_q <= ops_q[op_next];
                            state_q    <= StSetup;
                        end
                    end
                end
                StCompute: begin
                    if (tmr_zero) state_q <= StCapture;
                end
                StCapture: begin
                    result_q <= poly_bus.dut_result;
                    done_q   <= 1'b1;
                    busy_q   <= 1'b0;
                    state_q  <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign poly_bus.seq_data = seq_data_q;
    assign poly_bus.seq_go   = seq_go_q;
    assign result            = result_q;
    assign busy              = busy_q;
    assign done              = done_q;
    assign op_idx            = op_idx_q;

endmodule

// File: tb/tb_poly_operand_sequencer.sv
// Randomized bench: a default and a swept sequencer each drive a behavioural polynomial unit;
// every cycle's outputs are compared against a timing model derived from the phase lengths.
module tb_poly_operand_sequencer;

    logic       clk;
    logic       reset;
    logic       start;
    logic [7:0] a_in, b_in, c_in, x_in;
    int         cyc;

    logic [7:0] result0, result1;
    logic       busy0, busy1, done0, done1;
    logic [1:0] op_idx0, op_idx1;

    poly_operand_sequencer_if #(.WIDTH(8)) bus0 ();
    poly_operand_sequencer_if #(.WIDTH(8)) bus1 ();

    poly_operand_sequencer u_dut_def (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .a_in     (a_in),
        .b_in     (b_in),
        .c_in     (c_in),
        .x_in     (x_in),
        .poly_bus (bus0),
        .result   (result0),
        .busy     (busy0),
        .done     (done0),
        .op_idx   (op_idx0)
    );

    poly_operand_sequencer #(
        .WIDTH   (8),
        .HOLD    (1),
        .GAP     (3),
        .LATENCY (8)
    ) u_dut_sweep (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .a_in     (a_in),
        .b_in     (b_in),
        .c_in     (c_in),
        .x_in     (x_in),
        .poly_bus (bus1),
        .result   (result1),
        .busy     (busy1),
        .done     (done1),
        .op_idx   (op_idx1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] poly(input logic [7:0] a, input logic [7:0] b,
                                        input logic [7:0] c, input logic [7:0] x);
        int unsigned v;
        v = int'(a) * int'(x) * int'(x) + int'(b) * int'(x) + int'(c);
        return v[7:0];
    endfunction

    // Behavioural polynomial units: load the next operand on each rising go.
    logic [7:0] u0_ops [4];
    logic [7:0] u1_ops [4];
    logic [1:0] u0_cnt, u1_cnt;
    logic       u0_go, u1_go;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            u0_cnt          <= 2'd0;
            u0_go           <= 1'b0;
            bus0.dut_result <= 8'd0;
        end else begin
            u0_go <= bus0.seq_go;
            if (bus0.seq_go && !u0_go) begin
                u0_ops[u0_cnt] <= bus0.seq_data;
                u0_cnt         <= u0_cnt + 2'd1;
                if (u0_cnt == 2'd3)
                    bus0.dut_result <= poly(u0_ops[0], u0_ops[1], u0_ops[2], bus0.seq_data);
            end
        end
    end

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            u1_cnt          <= 2'd0;
            u1_go           <= 1'b0;
            bus1.dut_result <= 8'd0;
        end else begin
            u1_go <= bus1.seq_go;
            if (bus1.seq_go && !u1_go) begin
                u1_ops[u1_cnt] <= bus1.seq_data;
                u1_cnt         <= u1_cnt + 2'd1;
                if (u1_cnt == 2'd3)
                    bus1.dut_result <= poly(u1_ops[0], u1_ops[1], u1_ops[2], bus1.seq_data);
            end
        end
    end

    // Reference state per instance: start cycle of the current transaction and its operands.
    int         st_cyc [2];
    bit         fresh [2];
    logic [7:0] txn_ops [2][4];
    logic [7:0] res_prev [2];

    int n_vec;
    int n_err;

    function automatic int hold_of(input int d);
        return (d == 0) ? 2 : 1;
    endfunction

    function automatic int gap_of(input int d);
        return (d == 0) ? 2 : 3;
    endfunction

    function automatic int lat_of(input int d);
        return (d == 0) ? 6 : 8;
    endfunction

    function automatic int done_off(input int d);
        return 4 * (1 + hold_of(d) + gap_of(d)) + lat_of(d) + 2;
    endfunction

    // {result, seq_data, seq_go, busy, done, op_idx}
    function automatic logic [20:0] exp_vec(input int d, input int c);
        int         per, t, k, r;
        logic [7:0] data, res;
        logic       go, bsy, dn;
        logic [1:0] idx;
        if (fresh[d]) return '0;
        per  = 1 + hold_of(d) + gap_of(d);
        t    = c - st_cyc[d];
        data = txn_ops[d][3];
        res  = res_prev[d];
        go   = 1'b0;
        bsy  = 1'b1;
        dn   = 1'b0;
        idx  = 2'd3;
        if (t <= 4 * per) begin
            k    = (t - 1) / per;
            r    = (t - 1) % per;
            data = txn_ops[d][k];
            go   = (r >= 1) && (r <= hold_of(d));
            idx  = 2'(k);
        end else if (t >= done_off(d)) begin
            bsy = 1'b0;
            dn  = (t == done_off(d));
            res = poly(txn_ops[d][0], txn_ops[d][1], txn_ops[d][2], txn_ops[d][3]);
        end
        return {res, data, go, bsy, dn, idx};
    endfunction

    task automatic check_eq(input string tag, input logic [20:0] got, input logic [20:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_both(input string tag);
        check_eq($sformatf("def %s cyc%0d", tag, cyc),
                 {result0, bus0.seq_data, bus0.seq_go, busy0, done0, op_idx0}, exp_vec(0, cyc));
        check_eq($sformatf("swp %s cyc%0d", tag, cyc),
                 {result1, bus1.seq_data, bus1.seq_go, busy1, done1, op_idx1}, exp_vec(1, cyc));
    endtask

    task automatic cycle(input bit go, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] c, input logic [7:0] x);
        @(negedge clk);
        check_both("run");
        start = go;
        a_in  = a;
        b_in  = b;
        c_in  = c;
        x_in  = x;
        for (int d = 0; d < 2; d++) begin
            if (go && (fresh[d] || (cyc - st_cyc[d] >= done_off(d)))) begin
                res_prev[d] = fresh[d] ? 8'd0
                            : poly(txn_ops[d][0], txn_ops[d][1], txn_ops[d][2], txn_ops[d][3]);
                fresh[d]      = 1'b0;
                st_cyc[d]     = cyc;
                txn_ops[d][0] = a;
                txn_ops[d][1] = b;
                txn_ops[d][2] = c;
                txn_ops[d][3] = x;
            end
        end
        @(posedge clk);
    endtask

    task automatic cycle_rand(input bit go);
        cycle(go, 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
    endtask

    task automatic txn(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                       input logic [7:0] x, input int ign_t);
        cycle(1'b1, a, b, c, x);
        for (int t = 1; t <= 32; t++) cycle_rand(t == ign_t);
    endtask

    // Reset asserted between edges; outputs must clear before the next clock edge.
    task automatic do_reset();
        @(negedge clk);
        #2 reset = 1'b1;
        fresh[0] = 1'b1;
        fresh[1] = 1'b1;
        #1 check_both("async_rst");
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        a_in  = '0;
        b_in  = '0;
        c_in  = '0;
        x_in  = '0;
        n_vec = 0;
        n_err = 0;
        for (int d = 0; d < 2; d++) begin
            fresh[d]    = 1'b1;
            st_cyc[d]   = 0;
            res_prev[d] = 8'd0;
            for (int k = 0; k < 4; k++) txn_ops[d][k] = 8'd0;
        end

        do_reset();
        repeat (3) cycle_rand(1'b0);

        txn(8'd1, 8'd2, 8'd3, 8'd2, 0);
        txn(8'd16, 8'd0, 8'd5, 8'd4, 0);
        txn(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 10);

        // Abort during the C press, then recover with a fresh transaction.
        cycle_rand(1'b1);
        repeat (11) cycle_rand(1'b0);
        do_reset();
        repeat (4) cycle_rand(1'b0);
        txn(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 0);

        // Back-to-back: second start lands in the default instance's done cycle.
        cycle_rand(1'b1);
        repeat (27) cycle_rand(1'b0);
        cycle_rand(1'b1);
        repeat (32) cycle_rand(1'b0);

        for (int i = 0; i < 6; i++)
            txn(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
                int'($urandom_range(0, 20)));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
